// File: rtl/rv_fifo_if.sv
// Ready/valid FIFO bus bundle: upstream push handshake, downstream pop
// handshake and the occupancy count.
//   master : drives in_valid/in_data/out_ready, observes the rest
//   slave  : the FIFO side, drives in_ready/out_valid/out_data/count
interface rv_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/rv_fifo.sv
// Parameterized ready/valid FIFO, DEPTH entries of WIDTH bits.
// in_ready and out_valid decode the registered count only, so there is no
// combinational path between the upstream and downstream handshakes.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - rv_fifo_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/
//          out_data, count
module rv_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  rv_fifo_if.slave    bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_c, empty_c;
  logic             push_c, pop_c;

  // Handshake qualification from registered occupancy only
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = bus.in_valid & ~full_c;
  assign pop_c   = bus.out_ready & ~empty_c;

  assign bus.in_ready  = ~full_c;
  assign bus.out_valid = ~empty_c;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.count     = count_q;

  // Next-state: explicit wrap compare supports non-power-of-two DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage, not reset; reset suppresses the write so nothing is captured
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end
endmodule
